// File: rtl/mem_resp.sv
// Load-response stage: waits for the data RAM read strobe after a load request,
// extends the addressed byte/halfword/word and holds it until writeback takes it.
module mem_resp #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  da_ren,
    input  logic [1:0]  mem_ram_addr_lo,
    input  logic [2:0]  mem_ram_ext_op,
    input  logic        da_rvalid,
    input  logic [31:0] da_rdata,
    input  logic        wb_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_ld_valid,
    output logic        mem_ld_err,
    output logic        mem_stall
);

    // Extension op codes follow the load funct3 encoding used by the decoder.
    localparam logic [2:0] RAM_EXT_B  = 3'b000;
    localparam logic [2:0] RAM_EXT_H  = 3'b001;
    localparam logic [2:0] RAM_EXT_W  = 3'b010;
    localparam logic [2:0] RAM_EXT_BU = 3'b100;
    localparam logic [2:0] RAM_EXT_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;

    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [2:0]  op,
                                            input logic [1:0]  off);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (op)
            RAM_EXT_B:  extract = {{24{b[7]}}, b};
            RAM_EXT_BU: extract = {24'd0, b};
            RAM_EXT_H:  extract = {{16{h[15]}}, h};
            RAM_EXT_HU: extract = {16'd0, h};
            RAM_EXT_W:  extract = w;
            default:    extract = w;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        off_d     = off_q;
        rdata_d   = rdata_q;
        vld_d     = vld_q;
        err_d     = err_q;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (da_ren != 4'd0) begin
                    op_d    = mem_ram_ext_op;
                    off_d   = mem_ram_addr_lo;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                cnt_d     = (cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
                // A strobe in the final cycle still beats the timeout.
                if (da_rvalid) begin
                    rdata_d = extract(da_rdata, op_q, off_q);
                    err_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                mem_stall = !wb_ready;
                if (wb_ready) begin
                    vld_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                    if (da_ren != 4'd0) begin
                        op_d    = mem_ram_ext_op;
                        off_d   = mem_ram_addr_lo;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign mem_rdata    = rdata_q;
    assign mem_ld_valid = vld_q;
    assign mem_ld_err   = err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: table of load vectors plus hand-written backpressure,
// back-to-back and reset-mid-wait sequences; results checked via a scoreboard queue.
module tb_mem_resp;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  da_ren;
    logic [1:0]  mem_ram_addr_lo;
    logic [2:0]  mem_ram_ext_op;
    logic        da_rvalid;
    logic [31:0] da_rdata;
    logic        wb_ready;
    logic [31:0] mem_rdata;
    logic        mem_ld_valid;
    logic        mem_ld_err;
    logic        mem_stall;

    mem_resp #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .da_ren          (da_ren),
        .mem_ram_addr_lo (mem_ram_addr_lo),
        .mem_ram_ext_op  (mem_ram_ext_op),
        .da_rvalid       (da_rvalid),
        .da_rdata        (da_rdata),
        .wb_ready        (wb_ready),
        .mem_rdata       (mem_rdata),
        .mem_ld_valid    (mem_ld_valid),
        .mem_ld_err      (mem_ld_err),
        .mem_stall       (mem_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  off;
        logic [31:0] word;
        int          d;        // cycles from da_ren to da_rvalid; 0 = never answers
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each new result presented by the DUT is matched to the oldest expectation.
    always @(negedge clk) begin
        if (mem_ld_valid === 1'b1 && !prev_vld) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got data %h err %b expected no result", mem_rdata, mem_ld_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", mem_rdata, e.data);
                chk("sb_err", {31'd0, mem_ld_err}, {31'd0, e.err});
            end
        end
        prev_vld <= (mem_ld_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] off,
                         input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        da_ren          = 4'hF;
        mem_ram_ext_op  = op;
        mem_ram_addr_lo = off;
        tick();
        da_ren          = 4'h0;
    endtask

    task automatic wait_phase(input int d, input logic [31:0] word);
        int n;
        n = (d == 0) ? TIMEOUT : d;
        for (int i = 1; i <= n; i++) begin
            da_rvalid = (i == d);
            da_rdata  = (i == d) ? word : 32'hDEAD_BEEF;
            @(negedge clk);
            chk("wait_stall", {31'd0, mem_stall}, 32'd1);
            chk("wait_novalid", {31'd0, mem_ld_valid}, 32'd0);
            tick();
        end
        da_rvalid = 1'b0;
        @(negedge clk);
        chk("done_valid", {31'd0, mem_ld_valid}, 32'd1);
    endtask

    task automatic accept();
        wb_ready = 1'b1;
        @(negedge clk);
        chk("accept_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        wb_ready = 1'b0;
        @(negedge clk);
        chk("cleared_valid", {31'd0, mem_ld_valid}, 32'd0);
        chk("cleared_err", {31'd0, mem_ld_err}, 32'd0);
        chk("idle_stall", {31'd0, mem_stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;

        tbl[0]  = '{OP_W,  2'd0, 32'h1234_5678, 2,       32'h1234_5678, 1'b0};
        tbl[1]  = '{OP_B,  2'd3, 32'h80FF_1234, 1,       32'hFFFF_FF80, 1'b0};
        tbl[2]  = '{OP_BU, 2'd3, 32'h80FF_1234, 3,       32'h0000_0080, 1'b0};
        tbl[3]  = '{OP_B,  2'd1, 32'h80FF_1234, 1,       32'h0000_0012, 1'b0};
        tbl[4]  = '{OP_H,  2'd2, 32'h9ABC_0011, 2,       32'hFFFF_9ABC, 1'b0};
        tbl[5]  = '{OP_HU, 2'd0, 32'h9ABC_0011, 1,       32'h0000_0011, 1'b0};
        tbl[6]  = '{OP_HU, 2'd2, 32'h9ABC_0011, 4,       32'h0000_9ABC, 1'b0};
        tbl[7]  = '{OP_B,  2'd0, 32'h80FF_1234, 1,       32'h0000_0034, 1'b0};
        tbl[8]  = '{OP_H,  2'd0, 32'h1234_ABCD, 2,       32'hFFFF_ABCD, 1'b0};
        tbl[9]  = '{OP_BU, 2'd2, 32'h80FF_1234, 1,       32'h0000_00FF, 1'b0};
        tbl[10] = '{OP_W,  2'd1, 32'h5555_AAAA, 0,       32'h0000_0000, 1'b1};
        tbl[11] = '{OP_W,  2'd0, 32'hCAFE_BABE, TIMEOUT, 32'hCAFE_BABE, 1'b0};

        rstn = 1'b0; da_ren = 4'h0; mem_ram_addr_lo = 2'd0; mem_ram_ext_op = 3'd0;
        da_rvalid = 1'b0; da_rdata = 32'd0; wb_ready = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_valid", {31'd0, mem_ld_valid}, 32'd0);
        chk("rst_err", {31'd0, mem_ld_err}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        tick();

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].off, tbl[i].exp_data, tbl[i].exp_err);
            wait_phase(tbl[i].d, tbl[i].word);
            tick();
            accept();
            tick();
        end

        // Backpressure, then a new load issued in the same cycle as wb_ready.
        issue(OP_W, 2'd0, 32'h1111_2222, 1'b0);
        wait_phase(1, 32'h1111_2222);
        held = mem_rdata;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("bp_valid", {31'd0, mem_ld_valid}, 32'd1);
            chk("bp_data", mem_rdata, held);
            chk("bp_stall", {31'd0, mem_stall}, 32'd1);
        end
        tick();
        wb_ready = 1'b1;
        issue(OP_B, 2'd3, 32'hFFFF_FFA5, 1'b0);
        wb_ready = 1'b0;
        wait_phase(2, 32'hA500_0000);
        tick();
        accept();
        tick();

        // Reset in the middle of WAIT discards the load; a late strobe is ignored.
        da_ren = 4'h3; mem_ram_ext_op = OP_W; mem_ram_addr_lo = 2'd0;
        tick();
        da_ren = 4'h0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_rdata", mem_rdata, 32'd0);
        chk("midrst_valid", {31'd0, mem_ld_valid}, 32'd0);
        chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        da_rvalid = 1'b1; da_rdata = 32'h7777_7777;
        tick();
        da_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_valid", {31'd0, mem_ld_valid}, 32'd0);
            tick();
        end

        // Block still works normally after the reset.
        issue(OP_HU, 2'd2, 32'h0000_FEDC, 1'b0);
        wait_phase(1, 32'hFEDC_0000);
        tick();
        accept();
        tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
